wb_burst_initiator: RTL and testbench
=====================================

# wb_burst_initiator

Wishbone classic-cycle initiator that turns a command (address, length, direction, byte-select) into a sequence of single-beat bus cycles toward the user-area Wishbone slaves, e.g. the 4 KB user RAM. It streams write data in and read data out over valid/ready handshakes. The block sits between a local controller (LA-driven test logic or a future DMA) and the user-area Wishbone bus. It is the initiator counterpart of the existing responders.

## Interface
- ADDR_W, 32, Wishbone address width
- DATA_W, 32, Wishbone data width
- LEN_W, 8, burst length field width (beats = cmd_len + 1)
- TIMEOUT, 64, max cycles stb may wait for ack (used only with WBI_TIMEOUT_EN)

Ports:
- clk  in  1  clock
- reset  in  1  reset, synchronous, active-high
- cmd_valid  in  1  command offered
- cmd_ready  out  1  high only in IDLE
- cmd_addr  in  ADDR_W  start byte address (word aligned)
- cmd_len  in  LEN_W  beats minus one
- cmd_we  in  1  1 = write burst, 0 = read burst
- cmd_sel  in  4  byte select applied to every beat
- wr_valid / wr_ready  in / out  1  write data handshake
- wr_data  in  DATA_W  write beat data
- rd_valid / rd_ready  out / in  1  read data handshake
- rd_data  out  DATA_W  read beat data
- rd_last  out  1  marks final read beat
- done  out  1  one-cycle pulse at burst end
- err  out  1  one-cycle pulse with done when burst aborted by timeout
- wbm_cyc_o, wbm_stb_o, wbm_we_o  out  1  Wishbone strobes
- wbm_sel_o  out  4  byte select
- wbm_adr_o  out  ADDR_W  address
- wbm_dat_o  out  DATA_W  write data
- wbm_dat_i  in  DATA_W  read data
- wbm_ack_i  in  1  acknowledge

## Operation
- States: IDLE, WDATA, BUS, RESP, DONE.
- IDLE: cmd_ready=1. On cmd_valid, latch addr/len/we/sel and set beat counter = cmd_len. Go to WDATA if we, else BUS. Assert wbm_cyc_o.
- WDATA: wr_ready=1. On wr_valid, latch wr_data into wbm_dat_o and go to BUS.
- BUS: wbm_stb_o=1 with stable adr/we/sel/dat. Beats complete on wbm_ack_i.
  - Read beat: capture wbm_dat_i into rd_data, then go to RESP.
  - Write beat, not last: go to WDATA.
  - Last write beat: go to DONE.
- RESP: rd_valid=1, rd_last=(counter==0). On rd_ready: if last go to DONE, else go to BUS.
- After each beat, address += 4 and counter -= 1. The address wraps modulo 2^ADDR_W.
- DONE: done=1, cyc=0, go to IDLE.
- wbm_cyc_o stays high from command accept through the last beat. wbm_stb_o is low for at least one cycle between beats, so registered-ack slaves never see a back-to-back strobe.
- wbm_ack_i while stb=0 is ignored.
- Reset values: all outputs 0, except that cmd_ready=1 after reset releases; state is IDLE.
- Reset mid-burst: the burst is discarded at the reset edge. cyc/stb are 0 the following cycle, and no done is issued.

## Timing
- Command accepted at edge T. Read: stb=1 from T+1. Write: wr_ready=1 from T+1; stb=1 the cycle after the wr handshake.
- Ack sampled at edge A: stb=0 from A+1. For reads, rd_valid=1 from A+1.
- Minimum beat period (zero-wait slave, no backpressure) is 3 cycles.
- done is asserted one cycle after the final ack (write) or the final rd handshake (read). The next command is accepted no earlier than the cycle after done.
- cmd_len=0 gives one beat. cmd_len=255 gives 256 beats.

## Configuration
- WBI_TIMEOUT_EN defined: a counter clears on entering BUS and increments each BUS cycle without ack. On reaching TIMEOUT, drop cyc/stb, enter DONE, and pulse err with done. Remaining beats and data are discarded with no rd_valid.
  - If ack and threshold occur in the same cycle, ack wins.
- Undefined: no counter, err tied to 0, BUS waits indefinitely.

## Structure
- Package wbi_pkg: state enum, WB_WORD_BYTES=4, default TIMEOUT, LEN_W default.
- One sub-module, wbi_watchdog: clear/enable/expire counter, instantiated only under WBI_TIMEOUT_EN.

## Test plan
- Single write: addr 0x3800_0010, len 0, sel 0xF, data 0xDEAD_BEEF, against the 10-cycle-delay RAM slave. Expect one stb pulse with we=1, one done, err=0; a later read returns 0xDEAD_BEEF.
- Read burst of 4 from 0x3800_0000 (len=3) after writing 0,1,2,3. Expect rd_data 0,1,2,3, rd_last only on the 4th beat, addresses 0x…00/04/08/0C, and stb low between beats.
- Read backpressure: hold rd_ready=0 for 5 cycles on beat 2. Expect rd_valid/rd_data stable, no stb during the stall, and the burst completing correctly.
- Partial select: write sel=0x3, data 0xAAAA_5555 over 0xFFFF_FFFF. Expect readback 0xFFFF_5555.
- Timeout (macro on, TIMEOUT=64): slave never acks. Expect stb to drop after 64 cycles, done=err=1 for one cycle, then cmd_ready=1.
- Reset in BUS state of beat 2 of 4. Expect cyc/stb=0 the next cycle, no done, and a following command working normally.

Source files
------------

// File: rtl/wbi_pkg.sv
// Shared types and constants for the Wishbone burst initiator.
// Optional feature macro: WBI_TIMEOUT_EN (bus watchdog with err reporting).
package wbi_pkg;

    localparam int WB_WORD_BYTES   = 4;
    localparam int DEFAULT_TIMEOUT = 64;
    localparam int DEFAULT_LEN_W   = 8;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_WDATA = 3'd1,
        ST_BUS   = 3'd2,
        ST_RESP  = 3'd3,
        ST_DONE  = 3'd4
    } wbi_state_t;

endpackage

// File: rtl/wbi_watchdog.sv
// Cycle counter that flags a bus cycle left unacknowledged for TIMEOUT cycles.
// Instantiated by wb_burst_initiator only when WBI_TIMEOUT_EN is defined.
module wbi_watchdog
    import wbi_pkg::*;
#(
    parameter int TIMEOUT = DEFAULT_TIMEOUT
) (
    input  logic clk,
    input  logic reset,
    input  logic i_clear,
    input  logic i_enable,
    output logic o_expire
);

    localparam int CNT_W = $clog2(TIMEOUT + 1);

    logic [CNT_W-1:0] r_count;

    // Count enabled cycles since the last clear, saturating at TIMEOUT.
    always_ff @(posedge clk) begin
        if (reset || i_clear) begin
            r_count <= '0;
        end else if (i_enable && (r_count != CNT_W'(TIMEOUT))) begin
            r_count <= r_count + CNT_W'(1);
        end
    end

    // Expire fires on the TIMEOUT-th enabled cycle, so the caller leaves on that edge.
    assign o_expire = i_enable && (r_count == CNT_W'(TIMEOUT - 1));

endmodule

// File: rtl/wb_burst_initiator.sv
// Wishbone classic-cycle initiator: turns an (addr, len, we, sel) command into
// single-beat bus cycles, streaming write data in and read data out.
// Optional feature macro: WBI_TIMEOUT_EN (abort a stalled beat after TIMEOUT cycles).
module wb_burst_initiator
    import wbi_pkg::*;
#(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int LEN_W   = DEFAULT_LEN_W,
    parameter int TIMEOUT = DEFAULT_TIMEOUT
) (
    input  logic              clk,
    input  logic              reset,

    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [LEN_W-1:0]  cmd_len,
    input  logic              cmd_we,
    input  logic [3:0]        cmd_sel,

    input  logic              wr_valid,
    output logic              wr_ready,
    input  logic [DATA_W-1:0] wr_data,

    output logic              rd_valid,
    input  logic              rd_ready,
    output logic [DATA_W-1:0] rd_data,
    output logic              rd_last,

    output logic              done,
    output logic              err,

    output logic              wbm_cyc_o,
    output logic              wbm_stb_o,
    output logic              wbm_we_o,
    output logic [3:0]        wbm_sel_o,
    output logic [ADDR_W-1:0] wbm_adr_o,
    output logic [DATA_W-1:0] wbm_dat_o,
    input  logic [DATA_W-1:0] wbm_dat_i,
    input  logic              wbm_ack_i
);

    wbi_state_t        r_state;
    logic [ADDR_W-1:0] r_adr;
    logic [DATA_W-1:0] r_datO;
    logic [DATA_W-1:0] r_rdData;
    logic [LEN_W-1:0]  r_beatCnt;
    logic [3:0]        r_sel;
    logic              r_we;
    logic              r_cyc;
    logic              r_stb;
    logic              r_wrReady;
    logic              r_rdValid;
    logic              r_rdLast;
    logic              r_done;
    logic              r_err;
    logic              w_expire;

`ifdef WBI_TIMEOUT_EN
    logic w_wdClear;
    logic w_wdEnable;

    assign w_wdClear  = (r_state != ST_BUS);
    assign w_wdEnable = (r_state == ST_BUS) && !wbm_ack_i;

    wbi_watchdog #(
        .TIMEOUT (TIMEOUT)
    ) u_watchdog (
        .clk      (clk),
        .reset    (reset),
        .i_clear  (w_wdClear),
        .i_enable (w_wdEnable),
        .o_expire (w_expire)
    );
`else
    logic w_unusedTimeout;

    assign w_expire        = 1'b0;
    assign w_unusedTimeout = (TIMEOUT > 0);
`endif

    // Burst sequencer: one beat per WDATA/BUS or BUS/RESP pass, all outputs registered.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= ST_IDLE;
            r_adr     <= '0;
            r_datO    <= '0;
            r_rdData  <= '0;
            r_beatCnt <= '0;
            r_sel     <= '0;
            r_we      <= 1'b0;
            r_cyc     <= 1'b0;
            r_stb     <= 1'b0;
            r_wrReady <= 1'b0;
            r_rdValid <= 1'b0;
            r_rdLast  <= 1'b0;
            r_done    <= 1'b0;
            r_err     <= 1'b0;
        end else begin
            r_done <= 1'b0;
            r_err  <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (cmd_valid) begin
                        r_adr     <= cmd_addr;
                        r_beatCnt <= cmd_len;
                        r_we      <= cmd_we;
                        r_sel     <= cmd_sel;
                        r_cyc     <= 1'b1;
                        if (cmd_we) begin
                            r_wrReady <= 1'b1;
                            r_state   <= ST_WDATA;
                        end else begin
                            r_stb   <= 1'b1;
                            r_state <= ST_BUS;
                        end
                    end
                end
                ST_WDATA: begin
                    if (wr_valid) begin
                        r_datO    <= wr_data;
                        r_wrReady <= 1'b0;
                        r_stb     <= 1'b1;
                        r_state   <= ST_BUS;
                    end
                end
                ST_BUS: begin
                    if (wbm_ack_i) begin
                        r_stb     <= 1'b0;
                        r_adr     <= r_adr + ADDR_W'(WB_WORD_BYTES);
                        r_beatCnt <= r_beatCnt - LEN_W'(1);
                        if (!r_we) begin
                            r_rdData  <= wbm_dat_i;
                            r_rdValid <= 1'b1;
                            r_rdLast  <= (r_beatCnt == '0);
                            r_state   <= ST_RESP;
                        end else if (r_beatCnt == '0) begin
                            r_cyc   <= 1'b0;
                            r_done  <= 1'b1;
                            r_state <= ST_DONE;
                        end else begin
                            r_wrReady <= 1'b1;
                            r_state   <= ST_WDATA;
                        end
                    end else if (w_expire) begin
                        r_stb   <= 1'b0;
                        r_cyc   <= 1'b0;
                        r_done  <= 1'b1;
                        r_err   <= 1'b1;
                        r_state <= ST_DONE;
                    end
                end
                ST_RESP: begin
                    if (rd_ready) begin
                        r_rdValid <= 1'b0;
                        r_rdLast  <= 1'b0;
                        if (r_rdLast) begin
                            r_cyc   <= 1'b0;
                            r_done  <= 1'b1;
                            r_state <= ST_DONE;
                        end else begin
                            r_stb   <= 1'b1;
                            r_state <= ST_BUS;
                        end
                    end
                end
                ST_DONE: begin
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    // cmd_ready is held low while reset is asserted and rises as soon as it releases.
    assign cmd_ready = (r_state == ST_IDLE) && !reset;
    assign wr_ready  = r_wrReady;
    assign rd_valid  = r_rdValid;
    assign rd_data   = r_rdData;
    assign rd_last   = r_rdLast;
    assign done      = r_done;
    assign err       = r_err;
    assign wbm_cyc_o = r_cyc;
    assign wbm_stb_o = r_stb;
    assign wbm_we_o  = r_we;
    assign wbm_sel_o = r_sel;
    assign wbm_adr_o = r_adr;
    assign wbm_dat_o = r_datO;

endmodule

// File: tb/tb_wb_burst_initiator.sv
// Directed bench for wb_burst_initiator with a delay-configurable Wishbone RAM slave.
// Define WBI_TIMEOUT_EN for both RTL and bench to exercise the watchdog abort.
module tb_wb_burst_initiator;

    logic        clk;
    logic        reset;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [31:0] cmd_addr;
    logic [7:0]  cmd_len;
    logic        cmd_we;
    logic [3:0]  cmd_sel;
    logic        wr_valid;
    logic        wr_ready;
    logic [31:0] wr_data;
    logic        rd_valid;
    logic        rd_ready;
    logic [31:0] rd_data;
    logic        rd_last;
    logic        done;
    logic        err;
    logic        wbm_cyc_o;
    logic        wbm_stb_o;
    logic        wbm_we_o;
    logic [3:0]  wbm_sel_o;
    logic [31:0] wbm_adr_o;
    logic [31:0] wbm_dat_o;
    logic [31:0] wbm_dat_i;
    logic        wbm_ack_i;

    int compareCount  = 0;
    int mismatchCount = 0;

    wb_burst_initiator #(
        .ADDR_W  (32),
        .DATA_W  (32),
        .LEN_W   (8),
        .TIMEOUT (64)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_addr  (cmd_addr),
        .cmd_len   (cmd_len),
        .cmd_we    (cmd_we),
        .cmd_sel   (cmd_sel),
        .wr_valid  (wr_valid),
        .wr_ready  (wr_ready),
        .wr_data   (wr_data),
        .rd_valid  (rd_valid),
        .rd_ready  (rd_ready),
        .rd_data   (rd_data),
        .rd_last   (rd_last),
        .done      (done),
        .err       (err),
        .wbm_cyc_o (wbm_cyc_o),
        .wbm_stb_o (wbm_stb_o),
        .wbm_we_o  (wbm_we_o),
        .wbm_sel_o (wbm_sel_o),
        .wbm_adr_o (wbm_adr_o),
        .wbm_dat_o (wbm_dat_o),
        .wbm_dat_i (wbm_dat_i),
        .wbm_ack_i (wbm_ack_i)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Wishbone RAM slave: registered ack after slaveDelay extra cycles, byte-select writes.
    logic [31:0] mem [0:63];
    int          slaveDelay = 0;
    bit          slaveNoAck = 1'b0;
    int          waitCnt;

    always @(posedge clk) begin
        if (reset) begin
            wbm_ack_i <= 1'b0;
            wbm_dat_i <= '0;
            waitCnt   <= 0;
        end else begin
            wbm_ack_i <= 1'b0;
            if (wbm_cyc_o && wbm_stb_o && !wbm_ack_i && !slaveNoAck) begin
                if (waitCnt >= slaveDelay) begin
                    wbm_ack_i <= 1'b1;
                    waitCnt   <= 0;
                    if (wbm_we_o) begin
                        for (int b = 0; b < 4; b++) begin
                            if (wbm_sel_o[b]) mem[wbm_adr_o[7:2]][8*b +: 8] <= wbm_dat_o[8*b +: 8];
                        end
                    end else begin
                        wbm_dat_i <= mem[wbm_adr_o[7:2]];
                    end
                end else begin
                    waitCnt <= waitCnt + 1;
                end
            end else begin
                waitCnt <= 0;
            end
        end
    end

    // Bus monitor sampled 1 ns after each rising edge.
    logic [31:0] addrLog [0:299];
    logic        weLog   [0:299];
    logic [3:0]  selLog;
    int          stbPulses, stbCycles, doneCount, errCount, overlapCount, rdValidCycles;
    logic        prevStb = 1'b0;

    always begin
        @(posedge clk);
        #1;
        if (wbm_stb_o && !prevStb) begin
            if (stbPulses < 300) begin
                addrLog[stbPulses] = wbm_adr_o;
                weLog[stbPulses]   = wbm_we_o;
            end
            selLog = wbm_sel_o;
            stbPulses++;
        end
        if (wbm_stb_o) stbCycles++;
        if (done) doneCount++;
        if (err) errCount++;
        if (rd_valid && wbm_stb_o) overlapCount++;
        if (rd_valid) rdValidCycles++;
        prevStb = wbm_stb_o;
    end

    task automatic clearMon();
        stbPulses = 0; stbCycles = 0; doneCount = 0;
        errCount = 0; overlapCount = 0; rdValidCycles = 0;
    endtask

    task automatic issueCmd(input logic [31:0] addr, input logic [7:0] len,
                            input logic we, input logic [3:0] sel);
        int guard = 0;
        while (!cmd_ready && guard < 300) begin @(negedge clk); guard++; end
        if (!cmd_ready) begin
            compareCount++; mismatchCount++;
            $display("[TB] FAIL cmd_ready_wait: cmd_ready=%0b after %0d cycles, required 1", cmd_ready, guard);
        end
        cmd_valid = 1'b1; cmd_addr = addr; cmd_len = len; cmd_we = we; cmd_sel = sel;
        @(negedge clk);
        cmd_valid = 1'b0;
    endtask

    task automatic sendWord(input logic [31:0] data);
        int guard = 0;
        wr_valid = 1'b1; wr_data = data;
        while (!wr_ready && guard < 300) begin @(negedge clk); guard++; end
        if (!wr_ready) begin
            compareCount++; mismatchCount++;
            $display("[TB] FAIL wr_ready_wait: wr_ready=%0b after %0d cycles, required 1", wr_ready, guard);
        end
        @(negedge clk);
        wr_valid = 1'b0;
    endtask

    task automatic writeBurst(input logic [31:0] addr, input logic [7:0] len,
                              input logic [3:0] sel, input logic [31:0] base);
        issueCmd(addr, len, 1'b1, sel);
        for (int i = 0; i <= int'(len); i++) sendWord(base + 32'(i));
    endtask

    task automatic recvWord(input int stall, output logic [31:0] data, output logic last,
                            output bit stableOk, output bit gotBeat);
        int guard = 0;
        data = '0; last = 1'b0; stableOk = 1'b1; gotBeat = 1'b1;
        while (!rd_valid && guard < 300) begin @(negedge clk); guard++; end
        if (!rd_valid) begin
            compareCount++; mismatchCount++; gotBeat = 1'b0;
            $display("[TB] FAIL rd_valid_wait: rd_valid=%0b after %0d cycles, required 1", rd_valid, guard);
        end else begin
            data = rd_data; last = rd_last;
            repeat (stall) begin
                @(negedge clk);
                if (!rd_valid || rd_data !== data || wbm_stb_o) stableOk = 1'b0;
            end
            rd_ready = 1'b1;
            @(negedge clk);
            rd_ready = 1'b0;
        end
    endtask

    task automatic waitDone(output bit errSeen, output bit readyAtDone);
        int guard = 0;
        while (!done && guard < 300) begin @(negedge clk); guard++; end
        if (!done) begin
            compareCount++; mismatchCount++;
            $display("[TB] FAIL done_wait: done=%0b after %0d cycles, required 1", done, guard);
        end
        errSeen = err; readyAtDone = cmd_ready;
        @(negedge clk);
    endtask

    task automatic readSingle(input logic [31:0] addr, output logic [31:0] data);
        logic l; bit s, g, e, r;
        issueCmd(addr, 8'd0, 1'b0, 4'hF);
        recvWord(0, data, l, s, g);
        waitDone(e, r);
    endtask

    task automatic test_reset();
        reset = 1'b1; cmd_valid = 1'b0; cmd_addr = '0; cmd_len = '0; cmd_we = 1'b0;
        cmd_sel = '0; wr_valid = 1'b0; wr_data = '0; rd_ready = 1'b0;
        repeat (3) @(negedge clk);
        compareCount++; if (cmd_ready !== 1'b0) begin mismatchCount++; $display("[TB] FAIL rst_cmd_ready: got %0b expected 0", cmd_ready); end
        compareCount++; if (wbm_cyc_o !== 1'b0) begin mismatchCount++; $display("[TB] FAIL rst_cyc: got %0b expected 0", wbm_cyc_o); end
        compareCount++; if (wbm_stb_o !== 1'b0) begin mismatchCount++; $display("[TB] FAIL rst_stb: got %0b expected 0", wbm_stb_o); end
        compareCount++; if (wr_ready !== 1'b0) begin mismatchCount++; $display("[TB] FAIL rst_wr_ready: got %0b expected 0", wr_ready); end
        compareCount++; if (rd_valid !== 1'b0) begin mismatchCount++; $display("[TB] FAIL rst_rd_valid: got %0b expected 0", rd_valid); end
        compareCount++; if (done !== 1'b0 || err !== 1'b0) begin mismatchCount++; $display("[TB] FAIL rst_done_err: got %0b/%0b expected 0/0", done, err); end
        reset = 1'b0;
        @(negedge clk);
        compareCount++; if (cmd_ready !== 1'b1) begin mismatchCount++; $display("[TB] FAIL post_rst_cmd_ready: got %0b expected 1", cmd_ready); end
        compareCount++; if (wbm_cyc_o !== 1'b0) begin mismatchCount++; $display("[TB] FAIL post_rst_cyc: got %0b expected 0", wbm_cyc_o); end
    endtask

    task automatic test_single_write();
        bit e, r; logic [31:0] d;
        slaveDelay = 10; clearMon();
        writeBurst(32'h3800_0010, 8'd0, 4'hF, 32'hDEAD_BEEF);
        waitDone(e, r);
        compareCount++; if (stbPulses !== 1) begin mismatchCount++; $display("[TB] FAIL sw_stb_pulses: got %0d expected 1", stbPulses); end
        compareCount++; if (weLog[0] !== 1'b1) begin mismatchCount++; $display("[TB] FAIL sw_we: got %0b expected 1", weLog[0]); end
        compareCount++; if (addrLog[0] !== 32'h3800_0010) begin mismatchCount++; $display("[TB] FAIL sw_addr: got %h expected 38000010", addrLog[0]); end
        compareCount++; if (doneCount !== 1) begin mismatchCount++; $display("[TB] FAIL sw_done_count: got %0d expected 1", doneCount); end
        compareCount++; if (e !== 1'b0 || errCount !== 0) begin mismatchCount++; $display("[TB] FAIL sw_err: got %0b/%0d expected 0/0", e, errCount); end
        compareCount++; if (r !== 1'b0) begin mismatchCount++; $display("[TB] FAIL sw_ready_at_done: got %0b expected 0", r); end
        compareCount++; if (cmd_ready !== 1'b1) begin mismatchCount++; $display("[TB] FAIL sw_ready_after_done: got %0b expected 1", cmd_ready); end
        compareCount++; if (mem[4] !== 32'hDEAD_BEEF) begin mismatchCount++; $display("[TB] FAIL sw_mem: got %h expected deadbeef", mem[4]); end
        readSingle(32'h3800_0010, d);
        compareCount++; if (d !== 32'hDEAD_BEEF) begin mismatchCount++; $display("[TB] FAIL sw_readback: got %h expected deadbeef", d); end
    endtask

    task automatic test_read_burst(input int stallBeat, input int stallLen);
        bit e, r, s, g; logic [31:0] d; logic l;
        slaveDelay = 0;
        if (stallBeat < 0) begin
            writeBurst(32'h3800_0000, 8'd3, 4'hF, 32'd0);
            waitDone(e, r);
        end
        clearMon();
        issueCmd(32'h3800_0000, 8'd3, 1'b0, 4'hF);
        for (int i = 0; i < 4; i++) begin
            recvWord((i == stallBeat) ? stallLen : 0, d, l, s, g);
            if (!g) break;
            compareCount++; if (d !== 32'(i)) begin mismatchCount++; $display("[TB] FAIL rb_data[%0d]: got %h expected %h", i, d, 32'(i)); end
            compareCount++; if (l !== (i == 3)) begin mismatchCount++; $display("[TB] FAIL rb_last[%0d]: got %0b expected %0b", i, l, (i == 3)); end
            if (i == stallBeat) begin
                compareCount++; if (s !== 1'b1) begin mismatchCount++; $display("[TB] FAIL bp_stable: got %0b expected 1", s); end
            end
        end
        waitDone(e, r);
        for (int i = 0; i < 4; i++) begin
            compareCount++; if (addrLog[i] !== 32'h3800_0000 + 32'(4 * i) || weLog[i] !== 1'b0) begin
                mismatchCount++; $display("[TB] FAIL rb_addr[%0d]: got %h/we=%0b expected %h/we=0", i, addrLog[i], weLog[i], 32'h3800_0000 + 32'(4 * i));
            end
        end
        compareCount++; if (stbPulses !== 4) begin mismatchCount++; $display("[TB] FAIL rb_stb_pulses: got %0d expected 4", stbPulses); end
        compareCount++; if (overlapCount !== 0) begin mismatchCount++; $display("[TB] FAIL rb_stb_with_rd_valid: got %0d expected 0", overlapCount); end
        compareCount++; if (doneCount !== 1 || e !== 1'b0) begin mismatchCount++; $display("[TB] FAIL rb_done: got %0d err=%0b expected 1 err=0", doneCount, e); end
    endtask

    task automatic test_partial_select();
        bit e, r; logic [31:0] d;
        writeBurst(32'h3800_0020, 8'd0, 4'hF, 32'hFFFF_FFFF);
        waitDone(e, r);
        clearMon();
        writeBurst(32'h3800_0020, 8'd0, 4'h3, 32'hAAAA_5555);
        waitDone(e, r);
        compareCount++; if (selLog !== 4'h3) begin mismatchCount++; $display("[TB] FAIL ps_sel: got %h expected 3", selLog); end
        readSingle(32'h3800_0020, d);
        compareCount++; if (d !== 32'hFFFF_5555) begin mismatchCount++; $display("[TB] FAIL ps_readback: got %h expected ffff5555", d); end
    endtask

    task automatic test_addr_wrap();
        bit e, r, s, g; logic [31:0] d; logic l;
        logic [31:0] expAddr [4] = '{32'hFFFF_FFF8, 32'hFFFF_FFFC, 32'h0000_0000, 32'h0000_0004};
        writeBurst(32'hFFFF_FFF8, 8'd3, 4'hF, 32'h10);
        waitDone(e, r);
        clearMon();
        issueCmd(32'hFFFF_FFF8, 8'd3, 1'b0, 4'hF);
        for (int i = 0; i < 4; i++) begin
            recvWord(0, d, l, s, g);
            if (!g) break;
            compareCount++; if (d !== 32'h10 + 32'(i)) begin mismatchCount++; $display("[TB] FAIL wrap_data[%0d]: got %h expected %h", i, d, 32'h10 + 32'(i)); end
        end
        waitDone(e, r);
        for (int i = 0; i < 4; i++) begin
            compareCount++; if (addrLog[i] !== expAddr[i]) begin mismatchCount++; $display("[TB] FAIL wrap_addr[%0d]: got %h expected %h", i, addrLog[i], expAddr[i]); end
        end
    endtask

    task automatic test_max_len();
        bit e, r, s, g; logic [31:0] d; logic l;
        int beats = 0; int lastCount = 0; int lastIdx = -1;
        slaveDelay = 0; clearMon();
        issueCmd(32'h3800_0000, 8'd255, 1'b0, 4'hF);
        for (int i = 0; i < 256; i++) begin
            recvWord(0, d, l, s, g);
            if (!g) break;
            beats++;
            if (l) begin lastCount++; lastIdx = i; end
        end
        waitDone(e, r);
        compareCount++; if (beats !== 256) begin mismatchCount++; $display("[TB] FAIL max_beats: got %0d expected 256", beats); end
        compareCount++; if (lastCount !== 1 || lastIdx !== 255) begin mismatchCount++; $display("[TB] FAIL max_last: got count %0d idx %0d expected 1 idx 255", lastCount, lastIdx); end
        compareCount++; if (stbPulses !== 256) begin mismatchCount++; $display("[TB] FAIL max_stb_pulses: got %0d expected 256", stbPulses); end
        compareCount++; if (doneCount !== 1) begin mismatchCount++; $display("[TB] FAIL max_done: got %0d expected 1", doneCount); end
    endtask

    task automatic test_reset_midburst();
        bit e, r, s, g; logic [31:0] d; logic l;
        int guard = 0;
        slaveDelay = 3; clearMon();
        issueCmd(32'h3800_0000, 8'd3, 1'b0, 4'hF);
        recvWord(0, d, l, s, g);
        while (!wbm_stb_o && guard < 300) begin @(negedge clk); guard++; end
        compareCount++; if (wbm_stb_o !== 1'b1) begin mismatchCount++; $display("[TB] FAIL mid_stb_beat2: got %0b expected 1", wbm_stb_o); end
        reset = 1'b1;
        @(negedge clk);
        compareCount++; if (wbm_cyc_o !== 1'b0 || wbm_stb_o !== 1'b0) begin mismatchCount++; $display("[TB] FAIL mid_cyc_stb: got %0b/%0b expected 0/0", wbm_cyc_o, wbm_stb_o); end
        reset = 1'b0;
        repeat (20) @(negedge clk);
        compareCount++; if (doneCount !== 0) begin mismatchCount++; $display("[TB] FAIL mid_no_done: got %0d expected 0", doneCount); end
        clearMon();
        writeBurst(32'h3800_0030, 8'd0, 4'hF, 32'h1234_5678);
        waitDone(e, r);
        compareCount++; if (doneCount !== 1) begin mismatchCount++; $display("[TB] FAIL mid_next_done: got %0d expected 1", doneCount); end
        readSingle(32'h3800_0030, d);
        compareCount++; if (d !== 32'h1234_5678) begin mismatchCount++; $display("[TB] FAIL mid_next_readback: got %h expected 12345678", d); end
    endtask

`ifdef WBI_TIMEOUT_EN
    task automatic test_timeout();
        bit e, r;
        slaveNoAck = 1'b1; clearMon();
        issueCmd(32'h3800_0000, 8'd3, 1'b0, 4'hF);
        waitDone(e, r);
        compareCount++; if (stbCycles !== 64) begin mismatchCount++; $display("[TB] FAIL to_stb_cycles: got %0d expected 64", stbCycles); end
        compareCount++; if (e !== 1'b1 || errCount !== 1 || doneCount !== 1) begin mismatchCount++; $display("[TB] FAIL to_err_done: got err=%0b errs=%0d dones=%0d expected 1/1/1", e, errCount, doneCount); end
        compareCount++; if (rdValidCycles !== 0) begin mismatchCount++; $display("[TB] FAIL to_rd_valid: got %0d expected 0", rdValidCycles); end
        compareCount++; if (cmd_ready !== 1'b1 || wbm_cyc_o !== 1'b0) begin mismatchCount++; $display("[TB] FAIL to_idle: got ready=%0b cyc=%0b expected 1/0", cmd_ready, wbm_cyc_o); end
        slaveNoAck = 1'b0;
    endtask
`endif

    initial begin
        $display("[TB] starting wb_burst_initiator bench");
        test_reset();
        test_single_write();
        test_read_burst(-1, 0);
        test_read_burst(1, 5);
        test_partial_select();
        test_addr_wrap();
        test_max_len();
        test_reset_midburst();
`ifdef WBI_TIMEOUT_EN
        test_timeout();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, mismatchCount);
        $finish;
    end

endmodule
